// File: rtl/snake_dir_ctrl_pkg.sv
// Shared direction/state codes and helpers for the snake heading controller.
package snake_dir_ctrl_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Opposite pairs differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular buffer of queued headings with flush; exposes both head and tail entries.
module dir_fifo
  import snake_dir_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  dir_t            data_i,
  output dir_t            head_o,
  output dir_t            tail_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  dir_t            mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign head_o  = mem_q[rd_q];
  assign tail_o  = mem_q[wr_q - PtrW'(1)];
  assign count_o = count_q;

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= DIR_UP;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (do_pop) rd_q <= rd_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Run-state FSM, turn-request filter and step strobe for the snake; turns are queued in dir_fifo.
module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11,
  localparam int unsigned CntW    = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      button_pulse,
  input  logic            move_tick,
  input  logic            start_pulse,
  input  logic            pause_pulse,
  input  logic            game_over,
  output logic [1:0]      dir,
  output logic            step,
  output logic [1:0]      state,
  output logic [CntW-1:0] q_count,
  output logic [7:0]      drop_cnt
);

  state_t state_q, state_d;
  dir_t   dir_q;
  logic   step_q;
  logic [7:0] drop_q;

  logic   req_valid;
  dir_t   req_dir;
  logic [2:0] n_set, losers, drops;
  logic [8:0] drop_sum;
  logic   run, tick_ok, pop, push, reject, room, enter_idle;
  dir_t   head, tail, ref_dir;
  logic   fifo_full, fifo_empty;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (button_pulse[0])      req_dir = DIR_UP;
    else if (button_pulse[1]) req_dir = DIR_DOWN;
    else if (button_pulse[2]) req_dir = DIR_LEFT;
    else if (button_pulse[3]) req_dir = DIR_RIGHT;
    else                      req_valid = 1'b0;
  end

  assign n_set  = 3'(button_pulse[0]) + 3'(button_pulse[1]) + 3'(button_pulse[2])
                + 3'(button_pulse[3]);
  assign losers = req_valid ? n_set - 3'd1 : 3'd0;

  assign run        = (state_q == ST_RUN);
  // Any state change in the same cycle suppresses the tick.
  assign tick_ok    = run & move_tick & ~game_over & ~pause_pulse;
  assign pop        = tick_ok & ~fifo_empty;
  assign ref_dir    = fifo_empty ? dir_q : tail;
  assign room       = ~fifo_full | pop;
  assign push       = req_valid & run & (req_dir != ref_dir)
                    & (req_dir != opposite(ref_dir)) & room;
  assign reject     = req_valid & ~push;
  assign drops      = losers + 3'(reject);
  assign drop_sum   = {1'b0, drop_q} + 9'(drops);
  assign enter_idle = (state_q == ST_OVER) & start_pulse;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_pulse) state_d = ST_RUN;
      ST_RUN:   if (game_over) state_d = ST_OVER;
                else if (pause_pulse) state_d = ST_PAUSE;
      ST_PAUSE: if (game_over) state_d = ST_OVER;
                else if (pause_pulse) state_d = ST_RUN;
      ST_OVER:  if (start_pulse) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= INIT_DIR;
      step_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= tick_ok;
      drop_q  <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      if (enter_idle) dir_q <= INIT_DIR;
      else if (pop)   dir_q <= head;
    end
  end

  dir_fifo #(
    .Depth(QDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (enter_idle),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (req_dir),
    .head_o  (head),
    .tail_o  (tail),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  assign dir      = dir_q;
  assign step     = step_q;
  assign state    = state_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with QDEPTH=2, INIT_DIR=right.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button_pulse;
  logic       move_tick, start_pulse, pause_pulse, game_over;
  logic [1:0] dir;
  logic       step;
  logic [1:0] state;
  logic [1:0] q_count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  snake_dir_ctrl #(
    .QDEPTH   (2),
    .INIT_DIR (2'b11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_pulse (button_pulse),
    .move_tick    (move_tick),
    .start_pulse  (start_pulse),
    .pause_pulse  (pause_pulse),
    .game_over    (game_over),
    .dir          (dir),
    .step         (step),
    .state        (state),
    .q_count      (q_count),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    button_pulse = b;
    cyc();
    button_pulse = 4'b0;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
  endtask

  task automatic pstrobe();
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
  endtask

  task automatic sstrobe();
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_dir, input logic e_step,
                           input logic [1:0] e_state, input logic [1:0] e_q,
                           input logic [7:0] e_drop);
    check_eq({tag, ".dir"}, 32'(dir), 32'(e_dir));
    check_eq({tag, ".step"}, 32'(step), 32'(e_step));
    check_eq({tag, ".state"}, 32'(state), 32'(e_state));
    check_eq({tag, ".q"}, 32'(q_count), 32'(e_q));
    check_eq({tag, ".drop"}, 32'(drop_cnt), 32'(e_drop));
  endtask

  initial begin
    rst_n = 1'b0;
    button_pulse = 4'b0;
    move_tick = 1'b0;
    start_pulse = 1'b0;
    pause_pulse = 1'b0;
    game_over = 1'b0;
    #12;
    check_all("reset", 2'b11, 1'b0, 2'b00, 2'd0, 8'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Start and free-run three ticks with no turns.
    sstrobe();
    check_eq("start.state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("freerun.tick", 2'b11, 1'b1, 2'b01, 2'd0, 8'd0);
      cyc();
      check_eq("freerun.step_low", 32'(step), 32'd0);
    end

    // Double tap up then left before any tick.
    press(4'b0001);
    press(4'b0100);
    check_all("dtap.queued", 2'b11, 1'b0, 2'b01, 2'd2, 8'd0);
    tick();
    check_all("dtap.tick1", 2'b00, 1'b1, 2'b01, 2'd1, 8'd0);
    tick();
    check_all("dtap.tick2", 2'b10, 1'b1, 2'b01, 2'd0, 8'd0);

    // Heading left: reverse (right) and same (left) are both dropped.
    press(4'b1000);
    press(4'b0100);
    check_all("rev_same", 2'b10, 1'b0, 2'b01, 2'd0, 8'd2);
    tick();
    check_eq("rev_same.dir_after_tick", 32'(dir), 32'd2);

    // All four buttons: up wins, three losers dropped.
    press(4'b1111);
    check_all("multi", 2'b10, 1'b0, 2'b01, 2'd1, 8'd5);
    tick();
    check_eq("multi.dir", 32'(dir), 32'd0);

    // Fill queue (left, up), then right is rejected only for lack of room.
    press(4'b0100);
    press(4'b0001);
    check_eq("full.q", 32'(q_count), 32'd2);
    press(4'b1000);
    check_all("full.reject", 2'b00, 1'b0, 2'b01, 2'd2, 8'd6);
    // Same request coincident with a tick: pop frees room.
    button_pulse = 4'b1000;
    tick();
    button_pulse = 4'b0;
    check_all("full.pushpop", 2'b10, 1'b1, 2'b01, 2'd2, 8'd6);
    tick();
    check_all("q1.pre", 2'b00, 1'b1, 2'b01, 2'd1, 8'd6);
    // q_count==1 push+pop: reference is the popped entry (right), up is orthogonal.
    button_pulse = 4'b0001;
    tick();
    button_pulse = 4'b0;
    check_all("q1.pushpop", 2'b11, 1'b1, 2'b01, 2'd1, 8'd6);

    // Pause: ticks ignored, requests dropped, queue kept.
    pstrobe();
    check_eq("pause.state", 32'(state), 32'd2);
    tick();
    check_all("pause.tick", 2'b11, 1'b0, 2'b10, 2'd1, 8'd6);
    press(4'b0100);
    check_all("pause.press", 2'b11, 1'b0, 2'b10, 2'd1, 8'd7);
    pstrobe();
    check_eq("resume.state", 32'(state), 32'd1);
    // Tick coincident with pause: state change wins.
    pause_pulse = 1'b1;
    tick();
    pause_pulse = 1'b0;
    check_all("tick_pause", 2'b11, 1'b0, 2'b10, 2'd1, 8'd7);
    pstrobe();
    tick();
    check_all("resume.tick", 2'b00, 1'b1, 2'b01, 2'd0, 8'd7);
    press(4'b0100);
    check_eq("pre_over.q", 32'(q_count), 32'd1);

    // Game over with a coincident tick: no step, no pop.
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_all("over", 2'b00, 1'b0, 2'b11, 2'd1, 8'd7);
    tick();
    check_all("over.tick", 2'b00, 1'b0, 2'b11, 2'd1, 8'd7);
    sstrobe();
    check_all("to_idle", 2'b11, 1'b0, 2'b00, 2'd0, 8'd7);

    // Asynchronous reset mid-run.
    sstrobe();
    press(4'b0001);
    tick();
    press(4'b0100);
    check_all("prerst", 2'b00, 1'b0, 2'b01, 2'd1, 8'd7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'b11, 1'b0, 2'b00, 2'd0, 8'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Drop counter saturation: in IDLE every bit of 4'b1111 is a drop.
    for (int i = 0; i < 63; i++) press(4'b1111);
    check_eq("sat.252", 32'(drop_cnt), 32'd252);
    press(4'b1111);
    check_eq("sat.255", 32'(drop_cnt), 32'd255);
    press(4'b0001);
    check_eq("sat.hold", 32'(drop_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Direction and run-state controller sitting directly downstream of the button debouncer.
- Consumes its one-cycle debounced button pulses plus start/pause/game-over strobes and buffers turn requests in a small queue.
- Commits one queued turn per move tick, so fast double-taps between ticks are honoured in order.
- Feeds the snake body/movement logic with the current heading and a one-cycle step strobe.

Parameters:
- QDEPTH, 2, turn-queue depth; power of two, 2..8.
- INIT_DIR, 2'b11, heading after reset and on every return to IDLE.
- Direction encoding: 00 up, 01 down, 10 left, 11 right. Opposite pairs: 00/01, 10/11.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- button_pulse  in  4  one-cycle debounced pulses; [0] up, [1] down, [2] left, [3] right.
- move_tick  in  1  one-cycle strobe from the step-rate timer.
- start_pulse  in  1  one-cycle start request.
- pause_pulse  in  1  one-cycle pause/resume toggle.
- game_over  in  1  level from collision logic.
- dir  out  2  committed heading.
- step  out  1  one-cycle strobe: snake advances one cell in direction dir.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- q_count  out  $clog2(QDEPTH)+1  queued turn count.
- drop_cnt  out  8  saturating count of rejected requests.

Behaviour:
- Reset values (rst_n low, asynchronous): dir=INIT_DIR, step=0, state=IDLE, queue empty, q_count=0, drop_cnt=0. All outputs registered.
- FSM priority per cycle: game_over > pause_pulse > start_pulse.
  - IDLE -start_pulse-> RUN.
  - RUN -pause_pulse-> PAUSE.
  - PAUSE -pause_pulse-> RUN.
  - RUN or PAUSE -game_over-> OVER.
  - OVER -start_pulse-> IDLE.
- Entering IDLE flushes the queue and loads dir=INIT_DIR in the same edge.
- The queue is retained across PAUSE and OVER; OVER never updates dir.
- Request decode: if several button_pulse bits are set, priority is up>down>left>right. The winner is the request; each losing bit counts as one drop.
- Reference heading = queue tail if q_count>0, else dir (pre-update value).
- A request is enqueued only if all of the following hold:
  - state==RUN;
  - request != reference;
  - request is not the opposite of reference;
  - the queue has room after any same-cycle pop.
- Any other request is dropped and increments drop_cnt. drop_cnt saturates at 255. Equal-to-reference requests also count as drops.
- A full queue with a simultaneous pop accepts the push.
- move_tick in RUN, same edge:
  - if q_count>0: dir<=head and pop;
  - step asserts on the following cycle for exactly 1 cycle, with the new dir already visible.
  - Latency from move_tick to step is 1 cycle.
- move_tick outside RUN is ignored: no step, no pop.
- Simultaneous push and pop with q_count==1: the reference is the popped entry. Push is legal and q_count stays 1.
- If move_tick and a game_over or pause transition occur in the same cycle, the state change wins: no step and no pop.
- Queue implementation: circular buffer with rd/wr pointers wrapping modulo QDEPTH; q_count tracks occupancy 0..QDEPTH.

Decomposition:
- Shared package: direction codes DIR_UP/DOWN/LEFT/RIGHT, state codes ST_IDLE/RUN/PAUSE/OVER, opposite() function.
- One sub-module: dir_fifo (parameterised circular buffer with push, pop, full, empty, count, flush).
- FSM, request decode, drop counter and step register live in the top.

Test Plan:
- Reset then start_pulse, three move_ticks with no buttons -> state=01, dir=11 throughout, step pulses 1 cycle after each tick, q_count=0.
- In RUN with dir=11: pulse up, then left on the next cycle, before any tick.
  - Up is accepted; left is also accepted (orthogonal to tail=up), so q_count=2.
  - Tick 1 -> dir=00; tick 2 -> dir=10.
- With dir=11: pulse left (reverse), then right (same) -> both dropped, drop_cnt=2, q_count=0, dir unchanged after tick.
- QDEPTH=2: queue up,left, then pulse down while full with no tick -> down dropped, drop_cnt=1. Repeat with down coincident with move_tick -> pop up, push down, q_count=2.
- button_pulse=4'b1111 in one cycle with dir=10 -> up enqueued, drop_cnt+=3.
- Mid-run:
  - pause_pulse then move_tick -> no step, queue retained.
  - game_over -> state=11.
  - start_pulse -> state=00, dir=11, q_count=0.
  - rst_n low mid-run -> all outputs at reset values immediately, without waiting for clk.
